// File: rtl/bufctl_pkg.sv
// Constants and types shared by the buffer-controller token queues.
// Token value 0 is reserved to mean "no buffer".
package bufctl_pkg;

  localparam int TOKW = 2;
  localparam int NTOK = 3;
  localparam int CW   = 2;

  localparam logic [TOKW-1:0] TOK_NONE = 2'd0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } slot_state_e;

endpackage

// File: rtl/cpu_token_queue_chk.sv
// Token-conservation check: queued tokens plus the one held by the CPU can
// never exceed the number of buffers in a correctly operating system.
module cpu_token_queue_chk #(
  parameter int NTOK = 3,
  parameter int CW   = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic [CW-1:0] count,
  input logic          hold
);

  // Flag any cycle where more tokens are in flight than buffers exist
  a_tok_conserved: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(count) + int'(hold)) <= NTOK);

endmodule

// File: rtl/cpu_token_queue_tok_fifo.sv
// Circular token FIFO with occupancy count; a write while full is accepted
// only when a read frees a slot on the same edge.
module tok_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 3,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          rd_ok_s;
  logic          wr_ok_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  assign empty   = (count_r == CW'(0));
  assign full    = (count_r == CW'(DEPTH));
  assign count   = count_r;
  assign rd_ok_s = rd_en && !empty;
  assign wr_ok_s = wr_en && (!full || rd_ok_s);

  // Head entry, forced to zero while nothing is queued
  always_comb begin
    if (empty) begin
      rd_data = {W{1'b0}};
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cpu_token_queue.sv
// CPU-side token queue: orders snooper tokens, tracks the buffer the CPU holds
// and routes it to the forwarder (accept) or back to the snooper (reject).
module cpu_token_queue #(
  parameter int TOKW   = bufctl_pkg::TOKW,
  parameter int NTOK   = bufctl_pkg::NTOK,
  parameter int CW     = bufctl_pkg::CW,
  parameter bit CHK_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [TOKW-1:0] token_from_sn,
  input  logic            en_from_sn,
  output logic            cpu_rdy,
  output logic [TOKW-1:0] head,
  input  logic            cpu_acq,
  output logic [TOKW-1:0] cpu_tok,
  input  logic            cpu_done,
  input  logic            cpu_accept,
  output logic [TOKW-1:0] token_to_fwd,
  output logic            en_to_fwd,
  output logic [TOKW-1:0] token_to_sn,
  output logic            en_to_sn,
  output logic [CW-1:0]   count,
  output logic            err
);

  import bufctl_pkg::*;

  localparam logic [TOKW-1:0] NONE = TOKW'(TOK_NONE);

  slot_state_e     state_r, state_nxt;
  logic [TOKW-1:0] head_s;
  logic [CW-1:0]   count_s;
  logic            full_s, empty_s;
  logic            wr_en_s, pop_s, tok0_s, drop_s, stray_done_s;
  logic [TOKW-1:0] cpu_tok_r, cpu_tok_nxt;
  logic [TOKW-1:0] fwd_tok_r, fwd_tok_nxt, sn_tok_r, sn_tok_nxt;
  logic            fwd_en_r, fwd_en_nxt, sn_en_r, sn_en_nxt;
  logic            err_r;

  assign cpu_rdy      = (state_r == S_IDLE) && !empty_s;
  assign pop_s        = cpu_acq && cpu_rdy;
  assign wr_en_s      = en_from_sn && (token_from_sn != NONE);
  assign tok0_s       = en_from_sn && (token_from_sn == NONE);
  assign drop_s       = wr_en_s && full_s && !pop_s;
  assign stray_done_s = cpu_done && (state_r == S_IDLE);

  tok_fifo #(
    .W     (TOKW),
    .DEPTH (NTOK),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_s),
    .wr_data (token_from_sn),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Slot state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Slot next-state: acquire from IDLE, release on done
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE: begin
        if (pop_s) begin
          state_nxt = S_HOLD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cpu_done) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_HOLD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Slot outputs: held token and routing of the released token
  always_comb begin
    cpu_tok_nxt = cpu_tok_r;
    fwd_tok_nxt = fwd_tok_r;
    sn_tok_nxt  = sn_tok_r;
    fwd_en_nxt  = 1'b0;
    sn_en_nxt   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (pop_s) begin
          cpu_tok_nxt = head_s;
        end else begin
          cpu_tok_nxt = cpu_tok_r;
        end
      end
      S_HOLD: begin
        if (cpu_done) begin
          cpu_tok_nxt = NONE;
          if (cpu_accept) begin
            fwd_tok_nxt = cpu_tok_r;
            fwd_en_nxt  = 1'b1;
          end else begin
            sn_tok_nxt = cpu_tok_r;
            sn_en_nxt  = 1'b1;
          end
        end else begin
          cpu_tok_nxt = cpu_tok_r;
        end
      end
      default: cpu_tok_nxt = NONE;
    endcase
  end

  // Output registers; err is sticky until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_tok_r <= NONE;
      fwd_tok_r <= NONE;
      sn_tok_r  <= NONE;
      fwd_en_r  <= 1'b0;
      sn_en_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      cpu_tok_r <= cpu_tok_nxt;
      fwd_tok_r <= fwd_tok_nxt;
      sn_tok_r  <= sn_tok_nxt;
      fwd_en_r  <= fwd_en_nxt;
      sn_en_r   <= sn_en_nxt;
      if (tok0_s || drop_s || stray_done_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign head         = head_s;
  assign count        = count_s;
  assign cpu_tok      = cpu_tok_r;
  assign token_to_fwd = fwd_tok_r;
  assign en_to_fwd    = fwd_en_r;
  assign token_to_sn  = sn_tok_r;
  assign en_to_sn     = sn_en_r;
  assign err          = err_r;

  generate
    if (CHK_EN) begin : g_chk
      cpu_token_queue_chk #(
        .NTOK (NTOK),
        .CW   (CW)
      ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count_s),
        .hold  (state_r == S_HOLD)
      );
    end
  endgenerate

endmodule

// File: tb/tb_cpu_token_queue.sv
// Directed bench for cpu_token_queue: level checks after each edge plus a
// scoreboard of expected forwarder/snooper release strobes.
module tb_cpu_token_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] token_from_sn;
  logic       en_from_sn;
  logic       cpu_rdy;
  logic [1:0] head;
  logic       cpu_acq;
  logic [1:0] cpu_tok;
  logic       cpu_done;
  logic       cpu_accept;
  logic [1:0] token_to_fwd;
  logic       en_to_fwd;
  logic [1:0] token_to_sn;
  logic       en_to_sn;
  logic [1:0] count;
  logic       err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       fwd;
    logic [1:0] tok;
  } rel_t;

  rel_t exp_q[$];

  always #5 clk = ~clk;

  // The full-boundary case deliberately puts more tokens in flight than buffers
  cpu_token_queue #(.TOKW(2), .NTOK(3), .CW(2), .CHK_EN(1'b0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .token_from_sn (token_from_sn),
    .en_from_sn    (en_from_sn),
    .cpu_rdy       (cpu_rdy),
    .head          (head),
    .cpu_acq       (cpu_acq),
    .cpu_tok       (cpu_tok),
    .cpu_done      (cpu_done),
    .cpu_accept    (cpu_accept),
    .token_to_fwd  (token_to_fwd),
    .en_to_fwd     (en_to_fwd),
    .token_to_sn   (token_to_sn),
    .en_to_sn      (en_to_sn),
    .count         (count),
    .err           (err)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [1:0] t);
    en_from_sn    = 1'b1;
    token_from_sn = t;
    step();
    en_from_sn    = 1'b0;
    token_from_sn = 2'd0;
  endtask

  task automatic acq();
    cpu_acq = 1'b1;
    step();
    cpu_acq = 1'b0;
  endtask

  task automatic done(input logic acc, input logic [1:0] t);
    rel_t r;
    r.fwd = acc;
    r.tok = t;
    exp_q.push_back(r);
    cpu_done   = 1'b1;
    cpu_accept = acc;
    step();
    cpu_done   = 1'b0;
    cpu_accept = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  // Release monitor: every strobe must match the oldest expected release
  always @(negedge clk) begin
    if (en_to_fwd || en_to_sn) begin
      total++;
      if (en_to_fwd && en_to_sn) begin
        bad++;
        $display("FAIL both_strobes: fwd=%0d sn=%0d expected one", en_to_fwd, en_to_sn);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: fwd=%0d(tok %0d) sn=%0d(tok %0d) expected none",
                 en_to_fwd, token_to_fwd, en_to_sn, token_to_sn);
      end else begin
        rel_t e;
        rel_t a;
        e = exp_q.pop_front();
        a.fwd = en_to_fwd;
        a.tok = en_to_fwd ? token_to_fwd : token_to_sn;
        if (a !== e) begin
          bad++;
          $display("FAIL release: got fwd=%0d tok=%0d expected fwd=%0d tok=%0d",
                   a.fwd, a.tok, e.fwd, e.tok);
        end
      end
    end
  end

  initial begin
    token_from_sn = 2'd0;
    en_from_sn    = 1'b0;
    cpu_acq       = 1'b0;
    cpu_done      = 1'b0;
    cpu_accept    = 1'b0;

    // Reset then idle
    do_reset(2);
    step();
    check("rst_head", head, 0);
    check("rst_count", count, 0);
    check("rst_rdy", cpu_rdy, 0);
    check("rst_cpu_tok", cpu_tok, 0);
    check("rst_en_fwd", en_to_fwd, 0);
    check("rst_en_sn", en_to_sn, 0);
    check("rst_err", err, 0);

    // Ordering and accept path
    enq(2'd2);
    check("enq1_count", count, 1);
    check("enq1_head", head, 2);
    enq(2'd1);
    enq(2'd3);
    check("ord_count", count, 3);
    check("ord_head", head, 2);
    check("ord_rdy", cpu_rdy, 1);
    acq();
    check("acq_cpu_tok", cpu_tok, 2);
    check("acq_head", head, 1);
    check("acq_count", count, 2);
    check("acq_rdy", cpu_rdy, 0);
    acq();
    check("acq_in_hold_ignored", cpu_tok, 2);
    check("acq_in_hold_count", count, 2);
    done(1'b1, 2'd2);
    check("acc_cpu_tok", cpu_tok, 0);
    check("acc_en_fwd", en_to_fwd, 1);
    check("acc_tok_fwd", token_to_fwd, 2);
    step();
    check("acc_strobe_one_cycle", en_to_fwd, 0);
    check("acc_tok_fwd_held", token_to_fwd, 2);

    // Drain 1 to forwarder, then reject 3 back to snooper
    acq();
    check("acq2_cpu_tok", cpu_tok, 1);
    done(1'b1, 2'd1);
    check("q_holds_3_head", head, 3);
    check("q_holds_3_count", count, 1);
    acq();
    check("acq3_cpu_tok", cpu_tok, 3);
    check("acq3_count", count, 0);
    check("acq3_head", head, 0);
    done(1'b0, 2'd3);
    check("rej_en_sn", en_to_sn, 1);
    check("rej_tok_sn", token_to_sn, 3);
    check("rej_en_fwd", en_to_fwd, 0);
    check("rej_cpu_tok", cpu_tok, 0);
    step();
    check("rej_strobe_one_cycle", en_to_sn, 0);
    check("no_err_so_far", err, 0);

    // Full boundary: lone enqueue at full is dropped
    enq(2'd2);
    enq(2'd1);
    enq(2'd3);
    check("full_count", count, 3);
    enq(2'd1);
    check("drop_count", count, 3);
    check("drop_err", err, 1);
    check("drop_head", head, 2);

    // Full boundary: enqueue with pop at full is accepted
    do_reset(2);
    check("rst2_err", err, 0);
    enq(2'd1);
    enq(2'd2);
    enq(2'd3);
    en_from_sn    = 1'b1;
    token_from_sn = 2'd2;
    acq();
    en_from_sn    = 1'b0;
    token_from_sn = 2'd0;
    check("fullpop_count", count, 3);
    check("fullpop_err", err, 0);
    check("fullpop_cpu_tok", cpu_tok, 1);
    check("fullpop_head", head, 2);
    done(1'b1, 2'd1);
    acq();
    check("tail_a", cpu_tok, 2);
    done(1'b0, 2'd2);
    acq();
    check("tail_b", cpu_tok, 3);
    done(1'b1, 2'd3);
    acq();
    check("tail_new_tok", cpu_tok, 2);
    check("tail_count", count, 0);
    done(1'b0, 2'd2);

    // Simultaneous enqueue and acquire on an empty queue: no pop
    en_from_sn    = 1'b1;
    token_from_sn = 2'd3;
    acq();
    en_from_sn    = 1'b0;
    token_from_sn = 2'd0;
    check("empty_acq_cpu_tok", cpu_tok, 0);
    check("empty_acq_count", count, 1);
    check("empty_acq_head", head, 3);

    // Token 0 enqueue is rejected and flagged
    do_reset(1);
    enq(2'd0);
    check("tok0_err", err, 1);
    check("tok0_count", count, 0);

    // cpu_done in IDLE is flagged with no release
    do_reset(1);
    cpu_done   = 1'b1;
    cpu_accept = 1'b1;
    step();
    cpu_done   = 1'b0;
    cpu_accept = 1'b0;
    check("stray_done_err", err, 1);
    check("stray_done_fwd", en_to_fwd, 0);
    check("stray_done_sn", en_to_sn, 0);

    // Reset mid-operation discards held and queued tokens
    do_reset(1);
    enq(2'd1);
    enq(2'd2);
    enq(2'd3);
    acq();
    check("mid_cpu_tok", cpu_tok, 1);
    check("mid_count", count, 2);
    rst_n    = 1'b0;
    cpu_done = 1'b1;
    step();
    rst_n    = 1'b1;
    cpu_done = 1'b0;
    check("midrst_cpu_tok", cpu_tok, 0);
    check("midrst_count", count, 0);
    check("midrst_head", head, 0);
    check("midrst_en_fwd", en_to_fwd, 0);
    check("midrst_en_sn", en_to_sn, 0);
    step();
    check("midrst_after_fwd", en_to_fwd, 0);
    check("midrst_after_sn", en_to_sn, 0);
    check("midrst_err", err, 0);

    step();
    check("releases_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_token_queue.md
Name: cpu_token_queue

Overview:
- Consumer-side counterpart of the snooper's buffer-token queue in the ping/pang/pung buffer controller.
- The snooper hands over a token when it finishes filling a buffer. This block queues those tokens in arrival order and presents the oldest one to the CPU.
- It tracks the single buffer the CPU currently holds. When the CPU finishes, it routes that token to the forwarder (packet accepted) or back to the snooper queue (packet rejected).

Parameters:
- TOKW, 2, token width in bits; token value 0 means "no token".
- NTOK, 3, number of buffers/tokens in the system; this is also the queue depth.
- CW, 2, occupancy counter width; must satisfy 2^CW > NTOK.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- token_from_sn  in  TOKW  token of the buffer the snooper just filled.
- en_from_sn  in  1  one-cycle strobe: token_from_sn is valid.
- cpu_rdy  out  1  queue non-empty and CPU slot free.
- head  out  TOKW  oldest queued token; 0 when empty.
- cpu_acq  in  1  CPU takes head; honoured only while cpu_rdy=1.
- cpu_tok  out  TOKW  token held by CPU; 0 in IDLE.
- cpu_done  in  1  CPU finished with cpu_tok.
- cpu_accept  in  1  sampled with cpu_done: 1 = forward, 0 = reject.
- token_to_fwd  out  TOKW  token released to forwarder.
- en_to_fwd  out  1  one-cycle strobe for token_to_fwd.
- token_to_sn  out  TOKW  token returned to snooper queue.
- en_to_sn  out  1  one-cycle strobe for token_to_sn.
- count  out  CW  number of queued tokens (0..NTOK).
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n=0 at posedge):
  - queue empty, count=0, head=0;
  - CPU slot IDLE, cpu_tok=0;
  - all token_to_* outputs and en_to_* strobes 0, err=0;
  - any token held or queued at that moment is discarded.
- Queue: circular FIFO of NTOK entries with read pointer, write pointer, and count.
  - Pointers wrap NTOK-1 -> 0.
  - head is combinational from the read pointer entry, gated to 0 when count=0.
- Enqueue:
  - en_from_sn with token_from_sn != 0 writes at the write pointer; the token appears at head/count on the next cycle.
  - Token 0 is not written and sets err.
  - Enqueue while count=NTOK is dropped and sets err.
- CPU slot FSM:
  - States: IDLE, HOLD. cpu_rdy = (state==IDLE) && (count!=0).
  - IDLE -> HOLD: when cpu_acq && cpu_rdy, cpu_tok <= head, the head is popped, and count decrements. Latency is 1 cycle.
  - HOLD -> IDLE: on cpu_done, cpu_tok <= 0.
    - cpu_accept=1: token_to_fwd <= cpu_tok, en_to_fwd <= 1 for exactly one cycle.
    - cpu_accept=0: token_to_sn <= cpu_tok, en_to_sn <= 1 for exactly one cycle.
  - token_to_* registers hold their last value; only the en_to_* strobes return to 0.
  - cpu_acq while not cpu_rdy: ignored, no err.
  - cpu_done in IDLE: ignored, sets err.
- Simultaneous events:
  - Enqueue and pop in the same cycle: count is unchanged and both pointers advance. This holds even at count=NTOK, because the pop frees a slot in the same edge and the enqueue is accepted.
  - At count=0, an enqueue and cpu_acq in the same cycle: no pop, since cpu_rdy is 0. The token becomes head the next cycle.
  - cpu_done and cpu_acq in the same cycle cannot both apply, since acq requires IDLE. Any acq that cycle is ignored, and acquisition is possible from the following cycle.
- Invariant: count + (state==HOLD) never exceeds NTOK in legal operation. The implementation asserts this in simulation and does not enforce it in logic.

Decomposition:
- Shared package (bufctl_pkg):
  - TOKW, NTOK;
  - TOK_NONE = 0;
  - CPU slot state enum {S_IDLE, S_HOLD}.
  - The existing snooper/forwarder queue logic uses the same constants.
- One natural sub-module, tok_fifo:
  - parameterised TOKW/depth circular FIFO;
  - ports: clk, rst_n, wr_en, wr_data, rd_en, rd_data, count, full, empty.
- cpu_token_queue instantiates tok_fifo and adds the slot FSM, output routing, and error logic.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> head=0, count=0, cpu_rdy=0, cpu_tok=0, en_to_fwd=en_to_sn=0, err=0.
- Ordering and accept: enqueue 2, 1, 3 on consecutive cycles -> count=3, head=2. Then:
  - cpu_acq -> next cycle cpu_tok=2, head=1, count=2;
  - cpu_done with cpu_accept=1 -> next cycle en_to_fwd=1, token_to_fwd=2 for one cycle, cpu_tok=0.
- Reject path: queue holds 3, acquire, then cpu_done with cpu_accept=0 -> en_to_sn=1, token_to_sn=3 for one cycle; en_to_fwd stays 0.
- Full boundary:
  - with count=3 and IDLE, enqueue 1 alone -> dropped, err=1, count=3;
  - after reset, reach count=3, then enqueue and cpu_acq in the same cycle -> count stays 3, err=0, and the new token is at the tail.
- Protocol errors:
  - enqueue token 0 -> err=1, count unchanged;
  - after reset, cpu_done in IDLE -> err=1, no en_to_* strobe.
- Reset mid-operation: CPU in HOLD with cpu_tok=1 and count=2, assert rst_n=0 for one cycle -> cpu_tok=0, count=0, head=0, and no en_to_* strobe is emitted.
